// File: rtl/irq_controller.sv
`default_nettype none
// ============================================================================
// Module   : irq_controller
// Purpose  : Prioritised external interrupt aggregator for the core's meip_i,
//            with a Wishbone-classic register port for pending/enable/claim.
// Revision : 1.0
// ============================================================================
module irq_controller #(
    parameter int          NUM_SRC    = 8,
    parameter logic [31:0] RST_ENABLE = 32'h0
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic [NUM_SRC-1:0] irq_src_i,
    output logic               meip_o,
    input  logic               irq_ack_i,
    input  logic               wb_cyc_i,
    input  logic               wb_stb_i,
    input  logic               wb_we_i,
    input  logic [3:0]         wb_adr_i,
    input  logic [31:0]        wb_dat_i,
    output logic [31:0]        wb_dat_o,
    output logic               wb_ack_o
);

    localparam logic [1:0] c_REG_PENDING = 2'd0;
    localparam logic [1:0] c_REG_ENABLE  = 2'd1;
    localparam logic [1:0] c_REG_EDGE    = 2'd2;
    localparam logic [1:0] c_REG_CLAIM   = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [NUM_SRC-1:0] sync1_q, sync2_q, prev_q;
    logic [NUM_SRC-1:0] pend_q, pend_d;
    logic [NUM_SRC-1:0] en_q, en_d;
    logic [NUM_SRC-1:0] edge_q, edge_d;
    logic               claim_vld_q, claim_vld_d;
    logic [4:0]         claim_id_q, claim_id_d;
    logic               ack_q, ack_d;
    logic [31:0]        dat_q, dat_d;

    logic [NUM_SRC-1:0] w_req, w_rise, w_w1c, w_claim_clr;
    logic [4:0]         w_id;
    logic               w_go, w_wr, w_rd, w_claim, w_complete;
    logic               w_unused;

    assign w_go       = wb_cyc_i & wb_stb_i & ~ack_q;
    assign w_wr       = w_go & wb_we_i;
    assign w_rd       = w_go & ~wb_we_i;
    assign w_req      = pend_q & en_q;
    assign w_rise     = sync2_q & ~prev_q;
    assign w_w1c      = (w_wr && wb_adr_i[3:2] == c_REG_PENDING) ? wb_dat_i[NUM_SRC-1:0] : '0;
    assign w_claim    = (state_q == ST_REQ) & irq_ack_i & (|w_req);
    assign w_complete = w_wr & (wb_adr_i[3:2] == c_REG_CLAIM) & (state_q == ST_SERVICE);
    assign w_unused   = ^{wb_adr_i[1:0], wb_dat_i};

    // Descending scan so the lowest-numbered requesting source wins.
    always_comb begin
        w_id = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (w_req[i]) w_id = 5'(i);
        end
    end

    always_comb begin
        w_claim_clr = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            w_claim_clr[i] = w_claim && (w_id == 5'(i));
        end
    end

    // Edge bits: a fresh rising edge overrides both W1C and claim clears.
    assign pend_d = (edge_q & ((pend_q & ~w_w1c & ~w_claim_clr) | w_rise))
                  | (~edge_q & sync2_q);

    assign en_d   = (w_wr && wb_adr_i[3:2] == c_REG_ENABLE) ? wb_dat_i[NUM_SRC-1:0] : en_q;
    assign edge_d = (w_wr && wb_adr_i[3:2] == c_REG_EDGE)   ? wb_dat_i[NUM_SRC-1:0] : edge_q;
    assign ack_d  = wb_cyc_i & wb_stb_i & ~ack_q;

    always_comb begin
        dat_d = '0;
        if (w_rd) begin
            case (wb_adr_i[3:2])
                c_REG_PENDING: dat_d = 32'(pend_q);
                c_REG_ENABLE:  dat_d = 32'(en_q);
                c_REG_EDGE:    dat_d = 32'(edge_q);
                default:       dat_d = {claim_vld_q, 26'b0, claim_id_q};
            endcase
        end
    end

    always_comb begin
        state_d     = state_q;
        claim_vld_d = claim_vld_q;
        claim_id_d  = claim_id_q;
        case (state_q)
            ST_IDLE: begin
                if (|w_req) state_d = ST_REQ;
            end
            ST_REQ: begin
                if (w_claim) begin
                    state_d     = ST_SERVICE;
                    claim_vld_d = 1'b1;
                    claim_id_d  = w_id;
                end else if (~|w_req) begin
                    state_d = ST_IDLE;
                end
            end
            ST_SERVICE: begin
                if (w_complete) begin
                    state_d     = ST_IDLE;
                    claim_vld_d = 1'b0;
                    claim_id_d  = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= ST_IDLE;
            sync1_q     <= '0;
            sync2_q     <= '0;
            prev_q      <= '0;
            pend_q      <= '0;
            en_q        <= RST_ENABLE[NUM_SRC-1:0];
            edge_q      <= '0;
            claim_vld_q <= 1'b0;
            claim_id_q  <= '0;
            ack_q       <= 1'b0;
            dat_q       <= '0;
        end else begin
            state_q     <= state_d;
            sync1_q     <= irq_src_i;
            sync2_q     <= sync1_q;
            prev_q      <= sync2_q;
            pend_q      <= pend_d;
            en_q        <= en_d;
            edge_q      <= edge_d;
            claim_vld_q <= claim_vld_d;
            claim_id_q  <= claim_id_d;
            ack_q       <= ack_d;
            dat_q       <= dat_d;
        end
    end

    assign meip_o   = (state_q == ST_REQ);
    assign wb_ack_o = ack_q;
    assign wb_dat_o = dat_q;

endmodule
`default_nettype wire
